uart_loader: RTL



---
 rtl/uart_loader_pkg.sv | 18 +
 rtl/uart_loader_if.sv | 23 ++
 rtl/uart_loader_byte_packer.sv | 37 +++
 rtl/uart_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      DRAIN,
      DONE,
      ERROR
   } loader_state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_SIZE    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_OVERRUN = 2'b11;

endpackage

// File: rtl/uart_loader_if.sv
// Byte stream in from the UART receiver and word writes out to memory.
interface uart_loader_if #(
   parameter int ADDR_WIDTH = 15
);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  mem_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;

   // The loader consumes bytes and issues writes.
   modport master (
      input  rx_data, rx_valid, mem_ready,
      output mem_we, mem_addr, mem_wdata
   );

   // The environment supplies bytes and accepts writes.
   modport slave (
      output rx_data, rx_valid, mem_ready,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/uart_loader_byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words; used for both the
// length header and the image data.
module byte_packer
   import uart_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clear,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   logic [1:0]  r_cnt;
   // Only the three older bytes need storage; the fourth arrives with word_valid.
   logic [23:0] r_shift;

   // Count bytes within the current word and shift them in MSB-first.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_shift <= '0;
      end else if (i_clear) begin
         r_cnt   <= '0;
         r_shift <= '0;
      end else if (i_byte_valid) begin
         // NOTE: non-blocking so counter and shifter both see pre-edge values.
         r_cnt   <= r_cnt + 2'd1;
         r_shift <= {r_shift[15:0], i_byte};
      end
   end

   assign o_word       = {r_shift, i_byte};
   assign o_word_valid = i_byte_valid && !i_clear && (r_cnt == 2'd3);

endmodule

// File: rtl/uart_loader.sv
// Boot loader: parses a 32-bit big-endian word-count header, writes the
// following words to memory, then pulses cpu_start. Flags oversize images,
// inter-byte timeouts and write overruns.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int                       ADDR_WIDTH    = 15,
   parameter int                       TIMEOUT_WIDTH = 24,
   parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_MAX   = TIMEOUT_WIDTH'(10_000_000)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_restart,
   uart_loader_if.master       bus,
   output logic                o_loading,
   output logic                o_done,
   output logic                o_cpu_start,
   output logic                o_error,
   output logic [1:0]          o_err_code
);

   localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

   loader_state_t          r_state, w_state_next;
   logic [31:0]            r_len, w_len_next;
   logic [ADDR_WIDTH:0]    r_idx, w_idx_next, w_idx_eff;
   logic                   r_mem_we, w_we_next;
   logic [ADDR_WIDTH-1:0]  r_mem_addr, w_addr_next;
   logic [31:0]            r_mem_wdata, w_wdata_next;
   logic [TIMEOUT_WIDTH-1:0] r_tmo, w_tmo_next, w_tmo_inc;
   logic                   r_done, w_done_next;
   logic                   r_cpu_start, w_start_next;
   logic                   r_loading, r_error;
   logic [1:0]             r_err_code, w_err_next;

   logic                   w_pack_valid;
   logic [31:0]            w_word;
   logic                   w_word_valid;
   logic                   w_accept;
   logic                   w_timeout;

   // Bytes are only meaningful while parsing; restart discards any in flight.
   assign w_pack_valid = bus.rx_valid && (r_state inside {IDLE, HDR, DATA});

   byte_packer u_packer (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clear      (i_restart),
      .i_byte_valid (w_pack_valid),
      .i_byte       (bus.rx_data),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   assign w_accept  = r_mem_we && bus.mem_ready;
   assign w_tmo_inc = r_tmo + TIMEOUT_WIDTH'(1);
   assign w_timeout = !bus.rx_valid && (w_tmo_inc == TIMEOUT_MAX);
   // A word finishing in the same cycle as an acceptance goes to the next slot.
   assign w_idx_eff = w_accept ? r_idx + 1'b1 : r_idx;

   // Next-state and next-register values; restart overrides everything.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      w_state_next = r_state;
      w_len_next   = r_len;
      w_idx_next   = r_idx;
      w_we_next    = r_mem_we;
      w_addr_next  = r_mem_addr;
      w_wdata_next = r_mem_wdata;
      w_tmo_next   = r_tmo;
      w_done_next  = r_done;
      w_start_next = 1'b0;
      w_err_next   = r_err_code;

      if (i_restart) begin
         w_state_next = IDLE;
         w_len_next   = '0;
         w_idx_next   = '0;
         w_we_next    = 1'b0;
         w_addr_next  = '0;
         w_wdata_next = '0;
         w_tmo_next   = '0;
         w_done_next  = 1'b0;
         w_err_next   = ERR_NONE;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.rx_valid) begin
                  w_state_next = HDR;
                  w_tmo_next   = '0;
               end
            end
            HDR: begin
               w_tmo_next = bus.rx_valid ? '0 : w_tmo_inc;
               if (w_word_valid) begin
                  w_len_next = w_word;
                  if ({1'b0, w_word} > MAX_WORDS) begin
                     w_state_next = ERROR;
                     w_err_next   = ERR_SIZE;
                  end else if (w_word == 32'd0) begin
                     w_state_next = DONE;
                     w_done_next  = 1'b1;
                     w_start_next = 1'b1;
                  end else begin
                     w_state_next = DATA;
                     w_idx_next   = '0;
                  end
               end else if (w_timeout) begin
                  w_state_next = ERROR;
                  w_err_next   = ERR_TIMEOUT;
               end
            end
            DATA: begin
               w_tmo_next = bus.rx_valid ? '0 : w_tmo_inc;
               if (w_accept) begin
                  w_we_next  = 1'b0;
                  w_idx_next = r_idx + 1'b1;
               end
               if (w_word_valid) begin
                  if (r_mem_we && !bus.mem_ready) begin
                     // Previous word still pending: drop it and abort.
                     w_state_next = ERROR;
                     w_err_next   = ERR_OVERRUN;
                     w_we_next    = 1'b0;
                  end else begin
                     w_we_next    = 1'b1;
                     w_addr_next  = w_idx_eff[ADDR_WIDTH-1:0];
                     w_wdata_next = w_word;
                     if (32'(w_idx_eff) == r_len - 32'd1) w_state_next = DRAIN;
                  end
               end else if (w_timeout) begin
                  w_state_next = ERROR;
                  w_err_next   = ERR_TIMEOUT;
                  w_we_next    = 1'b0;
               end
            end
            DRAIN: begin
               if (w_accept) begin
                  w_we_next    = 1'b0;
                  w_idx_next   = r_idx + 1'b1;
                  w_state_next = DONE;
                  w_done_next  = 1'b1;
                  w_start_next = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State and all output registers; every output is a flop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_idx       <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_tmo       <= '0;
         r_done      <= 1'b0;
         r_cpu_start <= 1'b0;
         r_loading   <= 1'b0;
         r_error     <= 1'b0;
         r_err_code  <= ERR_NONE;
      end else begin
         r_state     <= w_state_next;
         r_len       <= w_len_next;
         r_idx       <= w_idx_next;
         r_mem_we    <= w_we_next;
         r_mem_addr  <= w_addr_next;
         r_mem_wdata <= w_wdata_next;
         r_tmo       <= w_tmo_next;
         r_done      <= w_done_next;
         r_cpu_start <= w_start_next;
         r_loading   <= (w_state_next inside {HDR, DATA, DRAIN});
         r_error     <= (w_state_next == ERROR);
         r_err_code  <= w_err_next;
      end
   end

   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign o_loading     = r_loading;
   assign o_done        = r_done;
   assign o_cpu_start   = r_cpu_start;
   assign o_error       = r_error;
   assign o_err_code    = r_err_code;

endmodule
